// File: rtl/cache_op_ctrl.sv
// Sequences one CACHE op from WB to the I- or D-cache maintenance port, holding WB until ack.
// Latency: req 1 cycle after sampling, done/flush 1 cycle after ack; watchdog aborts stuck requests.
module cache_op_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_vaddr,
  input  logic [ADDR_W-1:0] req_paddr,
  output logic              req_done,
  output logic              busy,
  output logic              ic_req,
  output logic [1:0]        ic_op,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_ack,
  output logic              dc_req,
  output logic [1:0]        dc_op,
  output logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_ack,
  output logic              flush_req,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              terr_q, terr_d;
  logic              is_index;
  logic              tgt_ack;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // op_q[2] doubles as the target select: ops 4-7 go to the D-cache.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    terr_d   = terr_q;
    is_index = 1'b0;
    tgt_ack  = op_q[2] ? dc_ack : ic_ack;
    case (req_op)
      3'd1, 3'd3, 3'd4, 3'd7: is_index = 1'b1;
      default:                is_index = 1'b0;
    endcase
    case (state_q)
      S_IDLE: begin
        if (req_valid && (req_op != 3'd0)) begin
          op_d    = req_op;
          addr_d  = is_index ? req_vaddr : req_paddr;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (tgt_ack) begin
          state_d = S_DONE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            terr_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come from registers only; non-target op/addr are forced to zero.
  assign busy        = (state_q != S_IDLE);
  assign ic_req      = (state_q == S_REQ) && !op_q[2];
  assign dc_req      = (state_q == S_REQ) &&  op_q[2];
  assign ic_op       = ic_req ? (op_q[1:0] - 2'd1) : 2'd0;
  assign dc_op       = dc_req ? op_q[1:0] : 2'd0;
  assign ic_addr     = ic_req ? addr_q : '0;
  assign dc_addr     = dc_req ? addr_q : '0;
  assign req_done    = (state_q == S_DONE);
  assign flush_req   = (state_q == S_DONE);
  assign timeout_err = terr_q;

endmodule

// File: doc/cache_op_ctrl.md
# cache_op_ctrl

Sequencer for MIPS CACHE instructions retiring in the write-back stage. It takes one cache operation from WB and routes it to the I-cache or D-cache maintenance port. It holds WB stalled with a req/ack handshake until the cache acknowledges, then signals completion and a one-cycle refetch flush. A watchdog aborts operations that a cache never acknowledges and records a sticky error.

## Interface
Parameters:
- TIMEOUT, 1024, maximum cycles a cache request stays asserted without ack; 0 disables the watchdog
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  WB holds a valid cache op (ws_valid and op != EMPTY)
- req_op  in  3  0 EMPTY, 1 I_IDX_INV, 2 I_HIT_INV, 3 I_IDX_STTAG, 4 D_IDX_WB_INV, 5 D_HIT_INV, 6 D_HIT_WB_INV, 7 D_IDX_STTAG
- req_vaddr  in  ADDR_W  virtual address, used by index ops (1,3,4,7)
- req_paddr  in  ADDR_W  physical address, used by hit ops (2,5,6)
- req_done  out  1  one-cycle pulse, op finished; WB ready_go
- busy  out  1  controller not in IDLE
- ic_req  out  1  I-cache maintenance request
- ic_op  out  2  0 idx_inv, 1 hit_inv, 2 idx_store_tag
- ic_addr  out  ADDR_W  I-cache op address
- ic_ack  in  1  I-cache completes the request in this cycle
- dc_req  out  1  D-cache maintenance request
- dc_op  out  2  0 idx_wb_inv, 1 hit_inv, 2 hit_wb_inv, 3 idx_store_tag
- dc_addr  out  ADDR_W  D-cache op address
- dc_ack  in  1  D-cache completes the request in this cycle
- flush_req  out  1  one-cycle pulse requesting pipeline refetch, coincident with req_done
- timeout_err  out  1  sticky, set on watchdog abort, cleared only by reset

## Operation
- Clock is clk. Reset is resetn, asynchronous and active-low.
- States: IDLE, REQ, DONE.
- IDLE
  - When req_valid is 1 and req_op != 0:
    - latch op_r = req_op and target = I for ops 1-3, D for ops 4-7;
    - latch addr_r = req_vaddr for index ops, req_paddr for hit ops;
    - clear cnt; go to REQ.
  - req_op == 0 is ignored.
- REQ
  - The target's req output is 1; the other cache's req is 0.
  - op and addr outputs are driven from op_r/addr_r and are stable for the whole state.
  - Mapping: I ops 1/2/3 give ic_op 0/1/2; D ops 4/5/6/7 give dc_op 0/1/2/3.
  - Non-target op/addr outputs are 0.
  - Target ack = 1 in a cycle: handshake completes, go to DONE.
  - No ack: cnt++.
  - If TIMEOUT != 0 and cnt == TIMEOUT-1 with no ack: set timeout_err, go to DONE.
  - The non-target ack is ignored.
  - req_valid and req_op are ignored in REQ. An issued op is never cancelled, even if WB is flushed.
- DONE
  - req_done = 1 and flush_req = 1 for exactly this cycle (also on timeout).
  - Unconditionally go to IDLE. req_valid is not sampled in DONE.
- WB must drop req_valid or present a new op by the cycle after req_done. A still-high req_valid in IDLE starts a new operation.
- busy = (state != IDLE).
- cnt width is clog2(TIMEOUT+1), minimum 1. It saturates and never wraps.

## Timing
- Reset: state IDLE. req_done, busy, ic_req, dc_req, flush_req and timeout_err are 0. ic_op, dc_op, ic_addr, dc_addr and all internal registers are 0.
- Reset asserted mid-REQ drops ic_req/dc_req asynchronously. No req_done is produced.
- Latency: req_valid sampled at edge T gives target req = 1 in cycle T+1. An ack in cycle T+1+k gives req_done in cycle T+2+k, and IDLE in T+3+k.
- Minimum operation is 3 cycles: IDLE, REQ, DONE.
- On timeout the req is high for exactly TIMEOUT cycles. req_done is high in the following cycle.
- An ack arriving in the same cycle as cnt reaches TIMEOUT-1 counts as success; timeout_err is not set.
- All outputs are decoded from registered state and latches only. There is no combinational path from any input to any output.

## Test plan
- Index invalidate, I-cache: req_op=1, vaddr=0x8000_1040, paddr=0x0000_1040, ic_ack in the first REQ cycle.
  - ic_req=1 for 1 cycle with ic_op=0 and ic_addr=0x8000_1040.
  - req_done and flush_req pulse 2 cycles after sampling; dc_req stays 0.
- Hit writeback-invalidate, D-cache: req_op=6, paddr=0x1FC0_0200, dc_ack delayed 5 cycles.
  - dc_req=1 for 6 cycles with dc_op=2 and dc_addr=0x1FC0_0200.
  - busy=1 for 7 cycles; one req_done.
- Timeout: TIMEOUT=8, req_op=4, no ack.
  - dc_req high exactly 8 cycles, then req_done=1 and timeout_err=1; timeout_err stays 1.
  - A later req_op=1 with ack completes normally.
- Boundary ack: TIMEOUT=8, ack on the 8th REQ cycle.
  - Completes normally; timeout_err=0.
- Stray and ignored inputs: ic_ack during a D op and req_valid toggling in REQ both have no effect. req_op=0 with req_valid=1 keeps busy=0.
- Back-to-back: req_valid held high with op 2 then op 5.
  - Second op starts in the cycle after DONE; two separate req_done pulses.
- resetn low during REQ clears all outputs immediately. The sequencer resumes cleanly after resetn rises.
